axis_eci_pkt_to_vc_nvc: RTL and testbench
=========================================

Name: axis_eci_pkt_to_vc_nvc

Overview:
Chunks ECI packets of up to PKT_SIZE words into VC-sized pieces of up to VC_SIZE words, with both sizes parametrised. Steers every chunk of a packet to one of N_VC output VC channels, selected per packet by a VC index. Each output channel has its own registered skid stage and marks the final chunk of each packet. Sits between the ECI packetizer and the per-VC link transmit queues; replaces the fixed 17-to-7, single-output chunker.

Parameters:
WORD_WIDTH, 64, ECI word width in bits
PKT_SIZE, 17, max words per ECI packet (>=1)
VC_SIZE, 7, max words per VC chunk (1..PKT_SIZE)
N_VC, 2, number of output VC channels (>=1)
PKT_SIZE_WIDTH, $clog2(PKT_SIZE+1), width of packet size field (derived; do not override)
VC_SIZE_WIDTH, $clog2(VC_SIZE+1), width of chunk size field (derived; do not override)
VC_IDX_WIDTH, max(1,$clog2(N_VC)), width of VC index (derived; do not override)

Ports:
aclk  in  1  clock; one clock domain
aresetn  in  1  asynchronous, active-low reset
eci_pkt_i  in  PKT_SIZE*WORD_WIDTH  packet words; word 0 in the LSBs
eci_pkt_size_i  in  PKT_SIZE_WIDTH  valid word count, 0..PKT_SIZE
eci_pkt_vc_i  in  VC_IDX_WIDTH  target output channel
eci_pkt_valid_i  in  1  packet valid
eci_pkt_ready_o  out  1  packet consumed; high only in the cycle the final chunk is accepted, or in a drop cycle
vc_pkt_o  out  N_VC*VC_SIZE*WORD_WIDTH  per-channel chunk words; unused words are 0
vc_pkt_size_o  out  N_VC*VC_SIZE_WIDTH  per-channel chunk word count, 1..VC_SIZE
vc_pkt_last_o  out  N_VC  chunk is the last chunk of its packet
vc_pkt_valid_o  out  N_VC  per-channel valid
vc_pkt_ready_i  in  N_VC  per-channel ready
drop_o  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset is async on aresetn low. During and after reset:
  - all vc_pkt_valid_o = 0; eci_pkt_ready_o = 0; drop_o = 0.
  - offset counter = 0; FSM in IDLE; both skid entries empty in every channel.
  - Data, size and last outputs are 0.
- Offset counter cnt is PKT_SIZE_WIDTH+1 bits, so cnt+VC_SIZE never wraps. All compares are unsigned at that width.
- Input is sampled live each cycle. Upstream must hold the packet, size and vc stable until eci_pkt_ready_o is high.
- FSM states:
  - IDLE: waiting for a packet, cnt = 0.
  - SEND: mid-packet, cnt > 0.
  - Channel index is taken from eci_pkt_vc_i every cycle. Holding it stable is an upstream obligation.
- Emit condition: eci_pkt_valid_i, size > 0, vc < N_VC, and the target channel skid has a free slot (s_ready).
- Each emit cycle:
  - chunk word i = eci_pkt_i[cnt+i] if cnt+i < size, else 0.
  - chunk size = min(size-cnt, VC_SIZE).
  - last = (size <= cnt+VC_SIZE).
  - If last: eci_pkt_ready_o = 1, cnt <= 0, go to IDLE. Otherwise cnt <= cnt+VC_SIZE, go to SEND.
- No emit while the target skid is full: cnt holds and eci_pkt_ready_o = 0.
- Drop, valid only in IDLE:
  - size == 0, or vc >= N_VC.
  - Response: eci_pkt_ready_o = 1 and drop_o = 1 in the same cycle; nothing is emitted.
- Latency: a chunk is presented on its vc_pkt_valid_o the cycle after the emit.
- Throughput: one chunk per cycle when downstream ready is held high.
- Each channel is an independent 2-entry skid register.
  - s_ready is registered: slot free is computed from occupancy only, never from vc_pkt_ready_i combinationally.
  - A stall on one channel blocks only packets targeting that channel. Packets still leave in input order, so there is head-of-line blocking.
- A stall mid-packet holds cnt. Chunks within a packet are never reordered or duplicated.
- Reset mid-packet discards the partial packet and skid contents. Upstream must re-present the whole packet.
- Output valid/data/size/last stay stable while valid && !ready (AXI-S rule).

Decomposition:
- Package eci_vc_pkg holds:
  - typedef eci_word_t [WORD_WIDTH-1:0].
  - FSM enum {IDLE, SEND}.
  - default constants ECI_PKT_SIZE=17 and ECI_VC_SIZE=7.
  - function chunk_size(size, cnt, vc_size).
- Sub-module axis_vc_skid: 2-entry registered slice carrying data, size and last, with async active-low reset. Instantiated N_VC times in a generate loop.

Test Plan:
- PKT_SIZE=17, VC_SIZE=7, N_VC=2; 17-word packet, vc=1, all ready -> channel 1 emits sizes 7,7,3 on 3 consecutive cycles, last=0,0,1. Words 14..16 appear in slots 0..2, slots 3..6 are 0. eci_pkt_ready_o is high in cycle 3 only. Channel 0 is idle throughout.
- 7-word packet, vc=0 -> single chunk: size 7, last=1. eci_pkt_ready_o high in the first cycle.
- 17-word packet to vc=0 with vc_pkt_ready_i[0] low for 5 cycles after the first chunk -> 2 chunks buffered, emit stalls, cnt holds at 14. On release, chunks 7,7,3 arrive in order with no duplication; eci_pkt_ready_o asserts once.
- Packet with size=0, then a packet with vc=3 -> each consumed in 1 cycle with drop_o=1; no vc_pkt_valid_o activity.
- 17-word packet to vc=1 followed by an 8-word packet to vc=0, vc1 ready low -> the vc=0 packet waits behind the vc=1 packet (in-order). After release, vc0 receives sizes 7,1, last on the second chunk.
- aresetn low for 1 cycle after the second chunk of a 17-word packet -> outputs clear asynchronously and FSM returns to IDLE. Re-presenting the packet yields a clean 7,7,3.

Source files
------------

// File: rtl/eci_vc_pkg.sv
// eci_vc_pkg
//   Shared types and helpers for the ECI packet to VC chunker.
//   - eci_word_t  : one ECI word at the default width
//   - fsm_state_t : chunker state (IDLE between packets, SEND mid-packet)
//   - chunk_size  : word count of the chunk starting at offset cnt
package eci_vc_pkg;

  localparam int ECI_WORD_WIDTH = 64;
  localparam int ECI_PKT_SIZE   = 17;
  localparam int ECI_VC_SIZE    = 7;

  typedef logic [ECI_WORD_WIDTH-1:0] eci_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_state_t;

  // Words left in the packet from offset cnt, capped at one chunk.
  function automatic logic [31:0] chunk_size(input logic [31:0] size,
                                             input logic [31:0] cnt,
                                             input logic [31:0] vc_size);
    logic [31:0] remaining;
    remaining = size - cnt;
    return (remaining < vc_size) ? remaining : vc_size;
  endfunction

endpackage

// File: rtl/axis_vc_skid.sv
// axis_vc_skid
//   Two-entry registered skid slice carrying one chunk (data, size, last).
//   s_ready is a register derived from occupancy only, so the upstream
//   chunker never sees a combinational path from m_ready.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_data/s_size/s_last   chunk in; s_valid/s_ready handshake
//   m_data/m_size/m_last   chunk out; m_valid/m_ready handshake
module axis_vc_skid
  import eci_vc_pkg::*;
#(
  parameter int DATA_WIDTH = 448,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [SIZE_WIDTH-1:0] s_size,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [SIZE_WIDTH-1:0] m_size,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + SIZE_WIDTH + 1;

  logic [1:0]               count_reg;
  logic [1:0]               count_next;
  logic [PAYLOAD_WIDTH-1:0] main_reg;
  logic [PAYLOAD_WIDTH-1:0] skid_reg;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     s_ready_reg;
  logic                     push;
  logic                     pop;

  assign payload = {s_last, s_size, s_data};
  assign push    = s_valid && s_ready_reg;
  assign pop     = (count_reg != 2'd0) && m_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // main_reg is always the head entry; skid_reg only holds the second
  // chunk while the head is stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg   <= 2'd0;
      s_ready_reg <= 1'b1;
      main_reg    <= '0;
      skid_reg    <= '0;
    end else begin
      count_reg   <= count_next;
      s_ready_reg <= (count_next != 2'd2);
      if (push) begin
        if (count_reg == 2'd0 || pop) begin
          main_reg <= payload;
        end else begin
          skid_reg <= payload;
        end
      end else if (pop && count_reg == 2'd2) begin
        main_reg <= skid_reg;
      end
    end
  end

  assign {m_last, m_size, m_data} = main_reg;
  assign m_valid = (count_reg != 2'd0);
  assign s_ready = s_ready_reg;

endmodule

// File: rtl/axis_eci_pkt_to_vc_nvc.sv
// axis_eci_pkt_to_vc_nvc
//   Splits an ECI packet (up to PKT_SIZE words) into chunks of up to
//   VC_SIZE words and steers every chunk of the packet to the output VC
//   channel named by eci_pkt_vc_i. Each channel has its own skid slice.
//   Packets with size 0 or an out-of-range VC are consumed and dropped.
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   eci_pkt_i/_size_i/_vc_i       packet words (word 0 in LSBs), count, VC
//   eci_pkt_valid_i/_ready_o      ready pulses when the packet is consumed
//   vc_pkt_o/_size_o/_last_o      per-channel chunk, count, last-chunk flag
//   vc_pkt_valid_o/_ready_i       per-channel handshake
//   drop_o                        one-cycle pulse per discarded packet
module axis_eci_pkt_to_vc_nvc
  import eci_vc_pkg::*;
#(
  parameter int WORD_WIDTH     = ECI_WORD_WIDTH,
  parameter int PKT_SIZE       = ECI_PKT_SIZE,
  parameter int VC_SIZE        = ECI_VC_SIZE,
  parameter int N_VC           = 2,
  parameter int PKT_SIZE_WIDTH = $clog2(PKT_SIZE + 1),
  parameter int VC_SIZE_WIDTH  = $clog2(VC_SIZE + 1),
  parameter int VC_IDX_WIDTH   = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [PKT_SIZE*WORD_WIDTH-1:0]        eci_pkt_i,
  input  logic [PKT_SIZE_WIDTH-1:0]             eci_pkt_size_i,
  input  logic [VC_IDX_WIDTH-1:0]               eci_pkt_vc_i,
  input  logic                                  eci_pkt_valid_i,
  output logic                                  eci_pkt_ready_o,
  output logic [N_VC*VC_SIZE*WORD_WIDTH-1:0]    vc_pkt_o,
  output logic [N_VC*VC_SIZE_WIDTH-1:0]         vc_pkt_size_o,
  output logic [N_VC-1:0]                       vc_pkt_last_o,
  output logic [N_VC-1:0]                       vc_pkt_valid_o,
  input  logic [N_VC-1:0]                       vc_pkt_ready_i,
  output logic                                  drop_o
);

  // One extra bit so cnt + VC_SIZE never wraps.
  localparam int CNT_WIDTH   = PKT_SIZE_WIDTH + 1;
  localparam int CHUNK_WIDTH = VC_SIZE * WORD_WIDTH;

  fsm_state_t               state_reg;
  logic [CNT_WIDTH-1:0]     cnt_reg;
  logic [CNT_WIDTH-1:0]     size_ext;
  logic [N_VC-1:0]          skid_ready;
  logic [N_VC-1:0]          skid_valid;
  logic [CHUNK_WIDTH-1:0]   chunk_data;
  logic [VC_SIZE_WIDTH-1:0] chunk_len;
  logic                     chunk_last;
  logic                     size_ok;
  logic                     target_ok;
  logic                     target_ready;
  logic                     emit;
  logic                     drop;

  assign size_ext   = CNT_WIDTH'(eci_pkt_size_i);
  assign size_ok    = (eci_pkt_size_i != '0);
  assign target_ok  = (32'(eci_pkt_vc_i) < N_VC);
  assign chunk_last = (size_ext <= cnt_reg + CNT_WIDTH'(VC_SIZE));
  assign chunk_len  = VC_SIZE_WIDTH'(chunk_size(32'(size_ext), 32'(cnt_reg), 32'(VC_SIZE)));

  // Mux the target channel's slot-free flag without indexing past N_VC.
  always_comb begin
    target_ready = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (32'(eci_pkt_vc_i) == 32'(v)) begin
        target_ready = skid_ready[v];
      end
    end
  end

  // Chunk slot i carries packet word cnt+i, zero beyond the packet end.
  always_comb begin
    chunk_data = '0;
    for (int i = 0; i < VC_SIZE; i++) begin
      for (int j = 0; j < PKT_SIZE; j++) begin
        if ((32'(cnt_reg) + 32'(i) == 32'(j)) && (32'(j) < 32'(eci_pkt_size_i))) begin
          chunk_data[i*WORD_WIDTH +: WORD_WIDTH] = eci_pkt_i[j*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  // aresetn gating keeps the handshake outputs low throughout reset.
  assign emit = aresetn && eci_pkt_valid_i && size_ok && target_ok && target_ready;
  assign drop = aresetn && eci_pkt_valid_i && (state_reg == IDLE) && !(size_ok && target_ok);

  assign eci_pkt_ready_o = (emit && chunk_last) || drop;
  assign drop_o          = drop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else if (emit) begin
      if (chunk_last) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        state_reg <= SEND;
        cnt_reg   <= cnt_reg + CNT_WIDTH'(VC_SIZE);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_VC; gi++) begin : g_vc
      assign skid_valid[gi] = emit && (32'(eci_pkt_vc_i) == 32'(gi));

      axis_vc_skid #(
        .DATA_WIDTH (CHUNK_WIDTH),
        .SIZE_WIDTH (VC_SIZE_WIDTH)
      ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (chunk_data),
        .s_size  (chunk_len),
        .s_last  (chunk_last),
        .s_valid (skid_valid[gi]),
        .s_ready (skid_ready[gi]),
        .m_data  (vc_pkt_o[gi*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .m_size  (vc_pkt_size_o[gi*VC_SIZE_WIDTH +: VC_SIZE_WIDTH]),
        .m_last  (vc_pkt_last_o[gi]),
        .m_valid (vc_pkt_valid_o[gi]),
        .m_ready (vc_pkt_ready_i[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_axis_eci_pkt_to_vc_nvc.sv
// Bench for axis_eci_pkt_to_vc_nvc: expected chunks are pushed per channel
// when a packet is driven and popped by a monitor on each accepted chunk.
// A second instance with three channels exercises the out-of-range VC drop.
module tb_axis_eci_pkt_to_vc_nvc;

  localparam int W     = 64;
  localparam int P     = 17;
  localparam int V     = 7;
  localparam int PKT_W = P * W;
  localparam int CH_W  = V * W;

  typedef struct {
    logic [CH_W-1:0] data;
    logic [2:0]      size;
    logic            last;
  } chunk_t;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b1;
  logic [PKT_W-1:0] eci_pkt = '0;
  logic [4:0]       eci_size = '0;
  logic [0:0]       eci_vc = '0;
  logic             eci_valid = 1'b0;
  logic             eci_ready;
  logic [2*CH_W-1:0] vc_pkt;
  logic [5:0]       vc_size;
  logic [1:0]       vc_last;
  logic [1:0]       vc_valid;
  logic [1:0]       vc_ready = 2'b11;
  logic             drop;

  logic [1:0]       eci_vc3 = '0;
  logic             eci_valid3 = 1'b0;
  logic             eci_ready3;
  logic [3*CH_W-1:0] vc_pkt3;
  logic [8:0]       vc_size3;
  logic [2:0]       vc_last3;
  logic [2:0]       vc_valid3;
  logic [2:0]       vc_ready3 = 3'b111;
  logic             drop3;

  int total = 0;
  int bad   = 0;

  chunk_t q0[$];
  chunk_t q1[$];

  bit              stall_q [2];
  logic [CH_W-1:0] stall_d [2];
  logic [2:0]      stall_s [2];
  logic            stall_l [2];

  always #5 aclk = ~aclk;

  axis_eci_pkt_to_vc_nvc #(
    .WORD_WIDTH (W), .PKT_SIZE (P), .VC_SIZE (V), .N_VC (2)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .eci_pkt_i       (eci_pkt),
    .eci_pkt_size_i  (eci_size),
    .eci_pkt_vc_i    (eci_vc),
    .eci_pkt_valid_i (eci_valid),
    .eci_pkt_ready_o (eci_ready),
    .vc_pkt_o        (vc_pkt),
    .vc_pkt_size_o   (vc_size),
    .vc_pkt_last_o   (vc_last),
    .vc_pkt_valid_o  (vc_valid),
    .vc_pkt_ready_i  (vc_ready),
    .drop_o          (drop)
  );

  axis_eci_pkt_to_vc_nvc #(
    .WORD_WIDTH (W), .PKT_SIZE (P), .VC_SIZE (V), .N_VC (3)
  ) dut3 (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .eci_pkt_i       (eci_pkt),
    .eci_pkt_size_i  (eci_size),
    .eci_pkt_vc_i    (eci_vc3),
    .eci_pkt_valid_i (eci_valid3),
    .eci_pkt_ready_o (eci_ready3),
    .vc_pkt_o        (vc_pkt3),
    .vc_pkt_size_o   (vc_size3),
    .vc_pkt_last_o   (vc_last3),
    .vc_pkt_valid_o  (vc_valid3),
    .vc_pkt_ready_i  (vc_ready3),
    .drop_o          (drop3)
  );

  // Monitor: one line per accepted chunk, plus hold-stable checks on stalls.
  always @(negedge aclk) begin
    if (aresetn) begin
      for (int c = 0; c < 2; c++) begin
        logic [CH_W-1:0] ad;
        logic [2:0]      as;
        logic            al;
        chunk_t          e;
        bit              have;
        ad = vc_pkt[c*CH_W +: CH_W];
        as = vc_size[c*3 +: 3];
        al = vc_last[c];
        if (stall_q[c]) begin
          total++;
          if (vc_valid[c] !== 1'b1 || ad !== stall_d[c] || as !== stall_s[c] || al !== stall_l[c]) begin
            bad++;
            $display("FAIL hold_stable ch%0d: got valid=%0b size=%0d last=%0b, want valid=1 size=%0d last=%0b",
                     c, vc_valid[c], as, al, stall_s[c], stall_l[c]);
          end
        end
        if (vc_valid[c] && vc_ready[c]) begin
          have = 1'b0;
          if (c == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
          end else if (c == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
          end
          total++;
          if (!have) begin
            bad++;
            $display("FAIL unexpected_chunk ch%0d: got size=%0d last=%0b, want no chunk", c, as, al);
          end else if (ad !== e.data || as !== e.size || al !== e.last) begin
            bad++;
            $display("FAIL chunk ch%0d: got size=%0d last=%0b data=%h, want size=%0d last=%0b data=%h",
                     c, as, al, ad, e.size, e.last, e.data);
          end else begin
            $display("chunk ch%0d size=%0d last=%0b ok", c, as, al);
          end
        end
        stall_q[c] = vc_valid[c] && !vc_ready[c];
        stall_d[c] = ad;
        stall_s[c] = as;
        stall_l[c] = al;
      end
      if (vc_valid3 !== 3'b000) begin
        total++;
        bad++;
        $display("FAIL dut3_valid: got %b, want 000", vc_valid3);
      end
    end else begin
      stall_q[0] = 1'b0;
      stall_q[1] = 1'b0;
    end
  end

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [PKT_W-1:0] p;
    for (int j = 0; j < P; j++) p[j*W +: W] = {$urandom, $urandom};
    return p;
  endfunction

  function automatic void push_expected(input logic [PKT_W-1:0] pkt, input int size, input int vc);
    for (int off = 0; off < size; off += V) begin
      chunk_t c;
      c.data = '0;
      for (int i = 0; i < V; i++) begin
        if (off + i < size) c.data[i*W +: W] = pkt[(off+i)*W +: W];
      end
      c.size = 3'((size - off < V) ? size - off : V);
      c.last = (off + V >= size);
      if (vc == 0) q0.push_back(c);
      else q1.push_back(c);
    end
  endfunction

  // Drives one packet until eci_ready; exp_cycles=0 skips the latency check.
  task automatic send_pkt(input logic [PKT_W-1:0] pkt, input int size, input int vc,
                          input bit exp_drop, input int exp_cycles);
    int cycles;
    if (!exp_drop) push_expected(pkt, size, vc);
    eci_pkt   = pkt;
    eci_size  = 5'(size);
    eci_vc    = 1'(vc);
    eci_valid = 1'b1;
    cycles = 0;
    forever begin
      @(negedge aclk);
      cycles++;
      if (eci_ready === 1'b1) begin
        total++;
        if (drop !== exp_drop) begin
          bad++;
          $display("FAIL drop_flag: got %b, want %b (size=%0d vc=%0d)", drop, exp_drop, size, vc);
        end
        if (exp_cycles > 0) begin
          total++;
          if (cycles != exp_cycles) begin
            bad++;
            $display("FAIL ready_cycle: got %0d, want %0d (size=%0d vc=%0d)", cycles, exp_cycles, size, vc);
          end
        end
        $display("packet size=%0d vc=%0d consumed after %0d cycles", size, vc, cycles);
        break;
      end
      if (drop !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL drop_early: got 1, want 0 (size=%0d vc=%0d)", size, vc);
      end
      if (cycles > 200) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got no ready in %0d cycles, want ready", cycles);
        break;
      end
    end
    @(posedge aclk);
    #1;
    eci_valid = 1'b0;
  endtask

  task automatic test_reset();
    eci_valid  = 1'b1;
    eci_size   = 5'd5;
    eci_valid3 = 1'b1;
    eci_vc3    = 2'd3;
    #1 aresetn = 1'b0;
    #11;
    total++;
    if (eci_ready !== 1'b0 || drop !== 1'b0 || eci_ready3 !== 1'b0 || drop3 !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: got ready=%b drop=%b ready3=%b drop3=%b, want 0", eci_ready, drop, eci_ready3, drop3);
    end
    total++;
    if (vc_valid !== 2'b00 || vc_size !== 6'd0 || vc_last !== 2'b00 || vc_pkt !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b size=%h last=%b, want all 0", vc_valid, vc_size, vc_last);
    end
    eci_valid  = 1'b0;
    eci_valid3 = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (vc_valid !== 2'b00 || eci_ready !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got valid=%b ready=%b, want 00 0", vc_valid, eci_ready);
    end
    $display("reset checked");
    @(posedge aclk);
    #1;
  endtask

  task automatic test_chunk17();
    send_pkt(rand_pkt(), 17, 1, 1'b0, 3);
  endtask

  task automatic test_single7();
    send_pkt(rand_pkt(), 7, 0, 1'b0, 1);
  endtask

  task automatic test_stall();
    fork
      send_pkt(rand_pkt(), 17, 0, 1'b0, 0);
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(posedge aclk);
          #1;
          if (vc_valid[0]) seen = 1'b1;
        end
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL stall_first_chunk: got no valid on ch0, want valid");
        end
        vc_ready[0] = 1'b0;
        repeat (5) begin
          @(negedge aclk);
          total++;
          if (eci_ready !== 1'b0 || vc_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: got ready=%b valid0=%b, want 0 1", eci_ready, vc_valid[0]);
          end
          @(posedge aclk);
          #1;
        end
        vc_ready[0] = 1'b1;
      end
    join
  endtask

  task automatic test_drop();
    send_pkt(rand_pkt(), 0, 0, 1'b1, 1);
    eci_size   = 5'd5;
    eci_vc3    = 2'd3;
    eci_valid3 = 1'b1;
    @(negedge aclk);
    total++;
    if (eci_ready3 !== 1'b1 || drop3 !== 1'b1) begin
      bad++;
      $display("FAIL drop_vc: got ready3=%b drop3=%b, want 1 1", eci_ready3, drop3);
    end else begin
      $display("packet vc=3 dropped");
    end
    @(posedge aclk);
    #1 eci_valid3 = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic test_hol();
    vc_ready[1] = 1'b0;
    fork
      begin
        send_pkt(rand_pkt(), 17, 1, 1'b0, 0);
        send_pkt(rand_pkt(), 8, 0, 1'b0, 0);
      end
      begin
        repeat (8) begin
          @(negedge aclk);
          total++;
          if (vc_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL hol_order: got valid0=%b, want 0", vc_valid[0]);
          end
        end
        @(posedge aclk);
        #1 vc_ready[1] = 1'b1;
      end
    join
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [PKT_W-1:0] p;
    p = rand_pkt();
    push_expected(p, 17, 1);
    eci_pkt   = p;
    eci_size  = 5'd17;
    eci_vc    = 1'b1;
    eci_valid = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn   = 1'b0;
    eci_valid = 1'b0;
    #1;
    total++;
    if (vc_valid !== 2'b00 || vc_size !== 6'd0 || vc_last !== 2'b00 || vc_pkt !== '0 || eci_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got valid=%b size=%h last=%b ready=%b, want all 0", vc_valid, vc_size, vc_last, eci_ready);
    end else begin
      $display("mid-packet reset cleared outputs");
    end
    q1.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    send_pkt(p, 17, 1, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    send_pkt(rand_pkt(), 1, 0, 1'b0, 1);
    send_pkt(rand_pkt(), 13, 1, 1'b0, 2);
    send_pkt(rand_pkt(), 14, 0, 1'b0, 2);
    send_pkt(rand_pkt(), 16, 1, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_chunk17();
    test_single7();
    test_stall();
    test_drop();
    test_hol();
    test_reset_mid();
    test_back_to_back();
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got q0=%0d q1=%0d pending, want 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
